// File: rtl/data_memory_responder_if.sv
// CPU-side request/response signals of the data memory responder (the shared data bus stays a plain inout port).
// Latency: none, wiring only.
// Backpressure: none; the master holds a request until mem_ready is seen.
interface data_memory_responder_if;
   logic [31:0] address;
   logic        mem_read;
   logic        mem_write;
   logic        mem_ready;
   logic        mem_error;

   modport master (
      output address, mem_read, mem_write,
      input  mem_ready, mem_error
   );

   modport slave (
      input  address, mem_read, mem_write,
      output mem_ready, mem_error
   );
endinterface

// File: rtl/data_memory_responder.sv
// Data memory responder: DEPTH x 64-bit store serving single CPU reads/writes over a shared tri-state data bus.
// Latency: mem_ready is a one-cycle strobe in the (WAIT_STATES+1)th cycle after the capture edge (1st cycle without waits).
// Backpressure: none; requests seen outside IDLE are ignored, the CPU keeps its request up until mem_ready.
// Build option: define DMEM_WAIT_STATE_EN to add the WAIT state and its countdown; otherwise IDLE goes straight to RESP.
module data_memory_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic                   clocc,
   input  logic                   reset,
   data_memory_responder_if.slave bus,
   inout  wire  [63:0]            data
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_capture;
   logic        w_req_any;
   logic        w_req_err;
   logic        w_resp;
   logic        w_oe;
   logic        w_commit;
   logic [63:0] w_rdat;

   logic [AW-1:0] r_idx;
   logic          r_rd;
   logic          r_wr;
   logic          r_err;
   logic [63:0]   r_wdat;
   logic [63:0]   r_mem [DEPTH];

`ifdef DMEM_WAIT_STATE_EN
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
`else
   // The wait-state count has no effect when the WAIT state is not built.
   logic [3:0]  w_unused_wait_states;
   assign w_unused_wait_states = 4'(WAIT_STATES);
`endif

   assign w_req_any = bus.mem_read | bus.mem_write;

   // Both strobes at once, a misaligned address or one past the last doubleword all become error transactions.
   assign w_req_err = (bus.mem_read & bus.mem_write)
                    | (bus.address[2:0] != 3'b000)
                    | (bus.address >= 32'(DEPTH * 8));

   // Next-state logic: accept only in IDLE, optionally count down wait cycles, RESP always lasts one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_req_any) begin
               w_capture = 1'b1;
`ifdef DMEM_WAIT_STATE_EN
               if (WAIT_STATES == 0) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = 4'(WAIT_STATES);
               end
`else
               w_state_nxt = S_RESP;
`endif
            end
         end
`ifdef DMEM_WAIT_STATE_EN
         S_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = S_RESP;
            end
         end
`endif
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and request capture; reset drops any transaction in flight.
   always_ff @(posedge clocc or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
`ifdef DMEM_WAIT_STATE_EN
         r_cnt   <= 4'd0;
`endif
         r_idx   <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
         r_wdat  <= 64'h0;
      end else begin
         r_state <= w_state_nxt;
`ifdef DMEM_WAIT_STATE_EN
         r_cnt   <= w_cnt_nxt;
`endif
         if (w_capture) begin
            r_idx  <= bus.address[AW+2:3];
            r_rd   <= bus.mem_read & ~bus.mem_write;
            r_wr   <= bus.mem_write & ~bus.mem_read;
            r_err  <= w_req_err;
            r_wdat <= data;
         end
      end
   end

   assign w_resp   = (r_state == S_RESP);
   assign w_commit = w_resp & r_wr & ~r_err;

   // Storage array; a good write lands on the edge that ends RESP, so an aborted write never commits.
   always_ff @(posedge clocc or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 64'h0;
         end
      end else if (w_commit) begin
         r_mem[r_idx] <= r_wdat;
      end
   end

   assign w_rdat = r_mem[r_idx];
   assign w_oe   = w_resp & r_rd & ~r_err;

   assign bus.mem_ready = w_resp;
   assign bus.mem_error = w_resp & r_err;
   assign data          = w_oe ? w_rdat : {64{1'bz}};

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter: DEPTH, default 64, number of 64-bit doublewords stored; power of two, 2 to 1024.
REQ-002 Parameter: WAIT_STATES, default 2, number of wait cycles between request capture and response; 0 to 15.
REQ-003 Port: clocc  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: address  input  32  byte address from the CPU.
REQ-006 Port: mem_read  input  1  read request, level-sampled.
REQ-007 Port: mem_write  input  1  write request, level-sampled.
REQ-008 Port: data  inout  64  shared tri-state data bus; the CPU drives write data, this block drives read data.
REQ-009 Port: mem_ready  output  1  one-cycle response strobe.
REQ-010 Port: mem_error  output  1  error flag, valid only while mem_ready = 1.

Function
REQ-011 The block SHALL implement three states: IDLE, WAIT and RESP.
REQ-012 IDLE: on a rising edge with exactly one of mem_read/mem_write = 1, the block SHALL capture address, the operation and data (for writes).
  - Next state is WAIT with counter = WAIT_STATES.
  - If WAIT_STATES = 0, next state is RESP directly.
REQ-013 WAIT: the counter SHALL decrement each cycle; at counter = 1 the next state is RESP.
REQ-014 RESP: mem_ready = 1 for exactly one cycle, then the state returns to IDLE.
  - mem_ready therefore rises WAIT_STATES+1 edges after the capture edge.
REQ-015 Requests present in WAIT or RESP SHALL be ignored; a request held high in the first IDLE cycle after RESP SHALL start a new transaction (back-to-back allowed).
REQ-016 Word index = address[log2(DEPTH)+2:3]; the access is an error if address[2:0] != 0 or address >= DEPTH*8.
REQ-017 mem_read = mem_write = 1 in IDLE SHALL be captured as an error transaction with no memory access.
REQ-018 Write, no error: memory[index] SHALL update with the captured data on the edge ending RESP; data SHALL stay Z throughout.
REQ-019 Read, no error: data SHALL be driven with memory[index] during RESP only; otherwise Z.
  - Read data SHALL reflect any write committed on an earlier edge.
REQ-020 Error transaction: mem_error = 1 together with mem_ready in RESP; memory unchanged; data stays Z.
REQ-021 mem_error SHALL be 0 whenever mem_ready = 0.

Reset
REQ-022 reset = 0 SHALL immediately, without waiting for a clock edge, force:
  - state IDLE, counter 0;
  - mem_ready = 0, mem_error = 0;
  - data released to Z;
  - all memory words = 64'h0.
REQ-023 Reset during WAIT or RESP SHALL abort the transaction; a pending write SHALL NOT be committed.
REQ-024 The first request SHALL be accepted on the first rising edge after reset returns to 1.

Configuration
REQ-025 Macro DMEM_WAIT_STATE_EN defined: WAIT state and counter are implemented as in REQ-012/REQ-013.
REQ-026 Macro DMEM_WAIT_STATE_EN undefined: no WAIT state and no counter; WAIT_STATES is ignored; IDLE goes directly to RESP and mem_ready rises 1 edge after capture.

Verification
REQ-027 Write then read (WAIT_STATES=2, macro defined): write 64'hDEAD_BEEF_0123_4567 to 0x10 -> mem_ready=1 on the 3rd edge after capture, mem_error=0; read 0x10 -> data=64'hDEAD_BEEF_0123_4567 during RESP, Z otherwise.
REQ-028 Post-reset read: reset pulse, then read 0x1F8 (DEPTH=64) -> data=64'h0, mem_error=0.
REQ-029 Errors: read 0x0C -> mem_ready=1, mem_error=1, data Z; write 0x200 (DEPTH=64) -> error, and a subsequent read of 0x0 returns 64'h0.
REQ-030 Simultaneous request: mem_read=mem_write=1 at 0x8 holding 64'h5 -> error; read 0x8 -> 64'h5.
REQ-031 Reset mid-write: write 64'hFF to 0x20, assert reset during WAIT -> mem_ready never asserted; read 0x20 -> 64'h0.
REQ-032 Back-to-back, macro undefined: mem_read held high at 0x8 -> mem_ready pulses every 2nd cycle, data=memory[1] each RESP.
